// File: rtl/led_flow_ctrl.sv
// LED pattern sequencer: tick-driven stepping with a debounced mode button.
module led_flow_ctrl #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned STEP_DIV   = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       tick_lvl,
  input  logic       en,
  input  logic       key_mode,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic [7:0] step_cnt,
  output logic       step_pulse
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    SHIFT_L = 2'd0,
    SHIFT_R = 2'd1,
    BOUNCE  = 2'd2,
    BLINK   = 2'd3
  } mode_e;

  logic             tick_q;
  logic             key_s1;
  logic             key_s2;
  logic             key_stable;
  logic             key_stable_nxt;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_cnt_nxt;
  logic [7:0]       div_cnt;
  logic [7:0]       div_nxt;
  logic [7:0]       cnt_nxt;
  logic [3:0]       led_nxt;
  logic             dir_up;
  logic             dir_nxt;
  logic             pulse_nxt;
  mode_e            mode_q;
  mode_e            mode_nxt;
  logic             rise_c;
  logic             press_c;
  logic             step_c;

  function automatic logic [3:0] start_pattern(input mode_e m);
    case (m)
      SHIFT_R: return 4'b1000;
      BLINK:   return 4'b0000;
      default: return 4'b0001;
    endcase
  endfunction

  assign mode = 2'(mode_q);

  // Input staging: tick edge reference and two-flop key synchronizer
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tick_q <= 1'b0;
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      tick_q <= tick_lvl;
      key_s1 <= key_mode;
      key_s2 <= key_s1;
    end
  end

  // Debounce: accept a key level only after it differs for DEB_CYCLES cycles
  always_comb begin
    deb_cnt_nxt    = '0;
    key_stable_nxt = key_stable;
    if (key_s2 != key_stable) begin
      if (deb_cnt == DEB_LAST) begin
        key_stable_nxt = key_s2;
      end else begin
        deb_cnt_nxt = deb_cnt + DEB_W'(1);
      end
    end
  end

  assign rise_c  = tick_lvl & ~tick_q;
  assign press_c = key_stable & ~key_stable_nxt;
  assign step_c  = en & rise_c & (div_cnt == DIV_LAST);

  // Next-state for mode, pattern, divider and step counter; a press beats a step
  always_comb begin
    mode_nxt  = mode_q;
    led_nxt   = led;
    dir_nxt   = dir_up;
    div_nxt   = div_cnt;
    cnt_nxt   = step_cnt;
    pulse_nxt = 1'b0;
    if (press_c) begin
      mode_nxt = mode_e'(2'(mode_q) + 2'd1);
      led_nxt  = start_pattern(mode_nxt);
      dir_nxt  = 1'b1;
      div_nxt  = '0;
      cnt_nxt  = '0;
    end else if (en && rise_c) begin
      if (step_c) begin
        div_nxt   = '0;
        cnt_nxt   = step_cnt + 8'd1;
        pulse_nxt = 1'b1;
        case (mode_q)
          SHIFT_L: led_nxt = {led[2:0], led[3]};
          SHIFT_R: led_nxt = {led[0], led[3:1]};
          BOUNCE: begin
            if (dir_up) begin
              led_nxt = {led[2:0], 1'b0};
              if (led_nxt == 4'b1000) dir_nxt = 1'b0;
            end else begin
              led_nxt = {1'b0, led[3:1]};
              if (led_nxt == 4'b0001) dir_nxt = 1'b1;
            end
          end
          default: led_nxt = ~led;
        endcase
      end else begin
        div_nxt = div_cnt + 8'd1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_stable <= 1'b1;
      deb_cnt    <= '0;
      mode_q     <= SHIFT_L;
      led        <= 4'b0001;
      dir_up     <= 1'b1;
      div_cnt    <= '0;
      step_cnt   <= '0;
      step_pulse <= 1'b0;
    end else begin
      key_stable <= key_stable_nxt;
      deb_cnt    <= deb_cnt_nxt;
      mode_q     <= mode_nxt;
      led        <= led_nxt;
      dir_up     <= dir_nxt;
      div_cnt    <= div_nxt;
      step_cnt   <= cnt_nxt;
      step_pulse <= pulse_nxt;
    end
  end

endmodule

// File: doc/led_flow_ctrl.md
LED_FLOW_CTRL -- requirements
Module: led_flow_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1_000_000, the number of consecutive cycles a key change must persist to be accepted (20 ms at 50 MHz).
REQ-002 SHALL have parameter STEP_DIV, default 1, the number of tick rising edges per pattern step (legal range 1..255).
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port tick_lvl, input, 1 bit: periodic level from the upstream counter stage, in the sys_clk domain.
REQ-006 SHALL have port en, input, 1 bit: step enable; 0 freezes the pattern.
REQ-007 SHALL have port key_mode, input, 1 bit: raw mode button, active-low, asynchronous, bouncing.
REQ-008 SHALL have port led, output, 4 bits: current LED pattern, registered.
REQ-009 SHALL have port mode, output, 2 bits: current mode, registered.
REQ-010 SHALL have port step_cnt, output, 8 bits: count of steps taken since reset or the last mode change, registered.
REQ-011 SHALL have port step_pulse, output, 1 bit: one-cycle strobe after each step, registered.

Function
REQ-012 SHALL register tick_lvl once into tick_q; rise = tick_lvl AND NOT tick_q.
REQ-013 SHALL keep an 8-bit divider that increments on each rise while en=1; when the divider reaches STEP_DIV-1 with rise present, a step occurs and the divider clears.
REQ-014 On a step, led, step_cnt and step_pulse SHALL update at that same clock edge; there is no added latency beyond the tick_q register.
REQ-015 step_pulse SHALL be 1 for exactly one cycle per step and 0 otherwise.
REQ-016 step_cnt SHALL increment by 1 per step and wrap from 255 to 0.
REQ-017 Mode 0 (SHIFT_L) SHALL start at 0001 and step as 0001 -> 0010 -> 0100 -> 1000 -> 0001.
REQ-018 Mode 1 (SHIFT_R) SHALL start at 1000 and step as 1000 -> 0100 -> 0010 -> 0001 -> 1000.
REQ-019 Mode 2 (BOUNCE) SHALL start at 0001 with direction up, giving 0001,0010,0100,1000,0100,0010,0001,0010,...
REQ-020 In BOUNCE, direction SHALL reverse on the step that lands on 1000 or 0001; the end pattern is not repeated.
REQ-021 Mode 3 (BLINK) SHALL start at 0000 and step as 0000 <-> 1111.
REQ-022 key_mode SHALL pass through a two-flop synchronizer; both flops reset to 1.
REQ-023 A debounce counter SHALL count while the synchronized key differs from key_stable and clear when they are equal.
REQ-024 When the debounce counter reaches DEB_CYCLES-1, key_stable SHALL take the synchronized value and the counter SHALL clear.
REQ-025 A press is a key_stable 1 -> 0 transition; release (0 -> 1) SHALL have no effect.
REQ-026 On a press, mode SHALL advance as 0 -> 1 -> 2 -> 3 -> 0 at the next edge.
REQ-027 At that same edge, led SHALL load the new mode's start pattern, and step_cnt, the divider and step_pulse SHALL clear, and BOUNCE direction SHALL reset to up.
REQ-028 A press and a step in the same cycle: the press SHALL win, the step SHALL be discarded, and step_pulse SHALL stay 0.
REQ-029 While en=0: rises SHALL be ignored, and led, step_cnt and the divider SHALL hold.
REQ-030 While en=0, key presses SHALL still change mode.
REQ-031 tick_q SHALL keep tracking tick_lvl regardless of en, so a level that is already high when en rises does not produce a step.

Reset
REQ-032 While sys_rst=1 at a clock edge, the outputs SHALL reset to led=0001, mode=0, step_cnt=0, step_pulse=0.
REQ-033 While sys_rst=1, tick_q SHALL reset to 0, the divider and debounce counter to 0, key_stable to 1, and direction to up.
REQ-034 Reset asserted mid-operation SHALL override all other events in that cycle.
REQ-035 The first rise after reset is released SHALL step normally.

Verification (bench uses DEB_CYCLES=4, STEP_DIV=1 unless stated)
REQ-036 Reset, then 5 tick rises with en=1 -> led 0010, 0100, 1000, 0001, 0010; step_cnt=5; five single-cycle step_pulse strobes.
REQ-037 mode=2, then 8 rises -> led 0010,0100,1000,0100,0010,0001,0010,0100.
REQ-038 key_mode low for 3 cycles then high -> no mode change; low for 10 cycles -> mode 0->1, led=1000, step_cnt=0; release -> no change.
REQ-039 Press accepted in the same cycle as a tick rise -> mode advances, led = new start pattern, step_pulse=0, step_cnt=0.
REQ-040 STEP_DIV=3, en toggled low across 2 rises -> a step only on every 3rd rise seen with en=1; tick_lvl already high when en rises -> no step.
REQ-041 260 steps, then sys_rst pulsed mid-run -> step_cnt wraps to 4 before reset; after reset all reset values, mode=0.
